uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first asserted req above last_grant, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    // last_grant itself is searched last, so a held request yields to others.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte sources onto one UART transmitter, round-robin,
// with a start timeout when the UART never reports it is transmitting.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_byte,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       uart_transmit,
  output logic [7:0]                 uart_tx_byte,
  input  logic                       uart_is_transmitting,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output state_t                     state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 11) ? $clog2(TIMEOUT_CYC + 1) : 11;

  // Handshake: a requester holds req and req_byte steady until it sees its
  // one-cycle ack; the byte is captured on that same edge and req may drop after.

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [CNT_W-1:0] tmo_cnt;
  logic [IDX_W-1:0] pick_winner;
  logic             pick_valid;
  logic [7:0]       win_byte;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner == IDX_W'(i)) win_byte = req_byte[i*8 +: 8];
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
      ack           <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      tmo_cnt       <= '0;
      last_grant    <= IDX_W'(NUM_REQ - 1);
    end else begin
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid && !uart_is_transmitting) begin
            uart_tx_byte     <= win_byte;
            grant_id         <= pick_winner;
            ack[pick_winner] <= 1'b1;
            uart_transmit    <= 1'b1;
            busy             <= 1'b1;
            tmo_cnt          <= '0;
            state            <= ST_START;
          end
        end
        ST_START: begin
          if (uart_is_transmitting) begin
            uart_transmit <= 1'b0;
            state         <= ST_WAIT_DONE;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Counter would reach TIMEOUT_CYC on this edge: give up on this byte.
            timeout_err   <= 1'b1;
            uart_transmit <= 1'b0;
            busy          <= 1'b0;
            last_grant    <= grant_id;
            state         <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction model, grant scoreboard, directed scenarios.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [31:0]  req_byte = '0;
  logic [3:0]   ack;
  logic         uart_transmit;
  logic [7:0]   uart_tx_byte;
  logic         uart_is_transmitting = 1'b0;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;
  state_t       state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_count = 0;
  int uart_mode = 0;  // 0 echo transmit one cycle late, 1 stuck low, 2 stuck high
  logic [15:0] exp_q[$];

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req                  (req),
    .req_byte             (req_byte),
    .ack                  (ack),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .grant_id             (grant_id),
    .busy                 (busy),
    .timeout_err          (timeout_err),
    .state_dbg            (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // UART model: busy follows transmit one cycle later.
  initial begin
    logic t;
    forever begin
      @(posedge clk);
      t = uart_transmit;
      #2;
      case (uart_mode)
        1:       uart_is_transmitting = 1'b0;
        2:       uart_is_transmitting = 1'b1;
        default: uart_is_transmitting = t;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  function automatic int rr_next(input logic [3:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return 0;
  endfunction

  bit         m_busy, m_drive, e_terr;
  int         m_t0, m_last, m_id;
  logic [7:0] m_byte;
  logic [3:0] e_ack;
  logic [3:0] p_req = '0;
  logic [31:0] p_byte = '0;
  logic       p_uit = 1'b0;
  logic       p_rst = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !p_rst) begin
        m_busy = 0; m_drive = 0; m_t0 = 0; m_last = NUM_REQ - 1; m_id = 0; m_byte = 8'h00;
        check("rst_ack", ack, 0);
        check("rst_transmit", uart_transmit, 0);
        check("rst_byte", uart_tx_byte, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
      end else begin
        e_ack = '0;
        e_terr = 0;
        if (!m_busy) begin
          if (p_req != 0 && !p_uit) begin
            m_id = rr_next(p_req, m_last);
            m_byte = p_byte[8*m_id +: 8];
            e_ack[m_id] = 1'b1;
            m_busy = 1; m_drive = 1; m_t0 = cyc;
          end
        end else if (m_drive) begin
          if (p_uit) m_drive = 0;
          else if (cyc - m_t0 == TMO) begin
            e_terr = 1; m_drive = 0; m_busy = 0; m_last = m_id;
          end
        end else if (!p_uit) begin
          m_busy = 0; m_last = m_id;
        end
        check("m_ack", ack, e_ack);
        check("m_ack_onehot", $onehot0(ack), 1);
        check("m_transmit", uart_transmit, m_drive);
        check("m_tx_byte", uart_tx_byte, m_byte);
        check("m_grant_id", grant_id, m_id);
        check("m_busy", busy, m_busy);
        check("m_terr", timeout_err, e_terr);
        check("m_state_idle", state_dbg == ST_IDLE, !m_busy);
        // scoreboard
        if (ack != 0) begin
          ack_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_grant: got id %0d byte %0h, expected no grant", grant_id, uart_tx_byte);
          end else begin
            check("sb_grant", {6'b0, grant_id, uart_tx_byte}, exp_q.pop_front());
          end
        end
      end
      p_req = req; p_byte = req_byte; p_uit = uart_is_transmitting; p_rst = rst_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req = '0;
    uart_mode = 0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == '0 && n < budget);
    check({name, "_ack_seen"}, 32'(ack != '0), 1);
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 40);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_wd(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && !uart_transmit) && n < 10);
    check({name, "_in_wait_done"}, state_dbg, ST_WAIT_DONE);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n, n0, a_c, t_c, last_c;
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    // single transfer, latency and completion
    do_reset();
    tick();
    n0 = ack_count;
    exp_q.push_back({8'd0, 8'h55});
    req_byte = 32'h0000_0055;
    req = 4'b0001;
    @(negedge clk); check("t1_ack_not_early", ack, 4'b0000);
    @(negedge clk); check("t1_ack", ack, 4'b0001);
    check("t1_byte", uart_tx_byte, 8'h55);
    check("t1_transmit", uart_transmit, 1);
    tick(); req = '0;
    wait_idle("t1", n);
    check("t1_busy_fall_cycles", n, 4);
    check("t1_one_transfer", ack_count - n0, 1);

    // all four requesting continuously: round-robin order
    do_reset();
    req_byte = 32'hA3A2_A1A0;
    req = 4'hF;
    for (int g = 0; g < 5; g++) exp_q.push_back({8'(exp_order[g]), 8'hA0 + 8'(exp_order[g])});
    last_c = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ack("t2", 12);
      order[g] = int'(grant_id);
      if (g > 0) check("t2_gap", cyc - last_c, 5);
      last_c = cyc;
    end
    tick(); req = '0;
    for (int g = 0; g < 5; g++) check("t2_order", order[g], exp_order[g]);
    wait_idle("t2", n);

    // UART never starts: timeout then next index
    do_reset();
    uart_mode = 1;
    req_byte = 32'h0000_B1B0;
    req = 4'b0011;
    exp_q.push_back({8'd0, 8'hB0});
    exp_q.push_back({8'd1, 8'hB1});
    wait_ack("t3_first", 4);
    check("t3_first_id", grant_id, 0);
    a_c = cyc;
    do @(negedge clk); while (!timeout_err && cyc - a_c < 40);
    check("t3_terr_seen", timeout_err, 1);
    check("t3_terr_delay", cyc - a_c, 16);
    check("t3_transmit_low", uart_transmit, 0);
    check("t3_busy_low", busy, 0);
    t_c = cyc;
    wait_ack("t3_next", 4);
    check("t3_next_id", grant_id, 1);
    check("t3_next_delay", cyc - t_c, 1);
    tick(); req = '0; uart_mode = 0;
    wait_idle("t3", n);

    // reset during WAIT_DONE, then UART busy holds off the grant
    do_reset();
    exp_q.push_back({8'd0, 8'h77});
    exp_q.push_back({8'd0, 8'h77});
    req_byte = 32'h0000_0077;
    req = 4'b0001;
    wait_ack("t4_first", 4);
    wait_wd("t4");
    tick();
    rst_n = 1'b0;
    uart_mode = 2;
    #1;
    check("t4_async_transmit", uart_transmit, 0);
    check("t4_async_byte", uart_tx_byte, 0);
    check("t4_async_ack", ack, 0);
    check("t4_async_grant_id", grant_id, 0);
    check("t4_async_busy", busy, 0);
    check("t4_async_terr", timeout_err, 0);
    check("t4_async_state", state_dbg, ST_IDLE);
    repeat (2) tick();
    rst_n = 1'b1;
    n0 = ack_count;
    repeat (6) @(negedge clk);
    check("t4_no_ack_while_uart_busy", ack_count - n0, 0);
    check("t4_uart_busy_seen", uart_is_transmitting, 1);
    tick(); uart_mode = 0;
    wait_ack("t4_after", 4);
    check("t4_after_id", grant_id, 0);
    check("t4_after_byte", uart_tx_byte, 8'h77);
    tick(); req = '0;
    wait_idle("t4", n);

    // byte changes after ack do not disturb the transfer
    do_reset();
    exp_q.push_back({8'd0, 8'h12});
    req_byte = 32'h0000_0012;
    req = 4'b0001;
    wait_ack("t5", 4);
    check("t5_byte_at_ack", uart_tx_byte, 8'h12);
    tick(); req_byte = 32'h0000_0034; req = '0;
    n = 0;
    do begin @(negedge clk); n++; check("t5_byte_stable", uart_tx_byte, 8'h12); end while (busy && n < 12);
    check("t5_idle", busy, 0);

    // short req pulse on port 2 while serving port 0
    do_reset();
    exp_q.push_back({8'd0, 8'h21});
    req_byte = 32'h0000_0021;
    req = 4'b0001;
    wait_ack("t6", 4);
    tick(); req = '0;
    wait_wd("t6");
    n0 = ack_count;
    tick(); req = 4'b0100;
    tick(); req = '0;
    repeat (8) @(negedge clk);
    check("t6_no_grant_port2", ack_count - n0, 0);
    check("t6_idle", busy, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
